scan_doubler: RTL and testbench

SCAN_DOUBLER -- requirements
Module: scan_doubler

---
 rtl/scan_doubler_if.sv | 21 ++
 rtl/scan_doubler.sv | 108 ++++++++++
 tb/tb_scan_doubler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_doubler_if.sv
// Video bundle between the colour PROM stage and the line doubler.
// The master drives 15 kHz pixels and syncs; the slave returns 31 kHz video.
interface scan_doubler_if;
   logic       pix_ce;
   logic [3:0] rgb_in;
   logic       hsync_in;
   logic       vsync_in;
   logic [3:0] rgb_out;
   logic       hsync_out;
   logic       vsync_out;

   modport master (
      output pix_ce, rgb_in, hsync_in, vsync_in,
      input  rgb_out, hsync_out, vsync_out
   );

   modport slave (
      input  pix_ce, rgb_in, hsync_in, vsync_in,
      output rgb_out, hsync_out, vsync_out
   );
endinterface

// File: rtl/scan_doubler.sv
// 15 kHz -> 31 kHz scan doubler: each input line is written into one bank of a
// two-line buffer while the other bank is replayed twice at double pixel rate.
module scan_doubler #(
   parameter int HS_WIDTH = 28,
   parameter int ADDR_W   = 9
) (
   input  logic          clk,
   input  logic          nRESET,
   scan_doubler_if.slave vid
);
   localparam int                DEPTH = 2 ** (ADDR_W + 1);
   localparam logic [ADDR_W-1:0] X_MAX = '1;
   localparam logic [ADDR_W-1:0] X_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] HS_W  = ADDR_W'(HS_WIDTH);

   logic [3:0]        mem [DEPTH];
   logic [3:0]        rd_data_q;

   logic              hs_prev_q;
   logic              vs_hold_q;
   logic [ADDR_W-1:0] wr_x_q, wr_x_d;
   logic              wr_bank_q, wr_bank_d;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] line_len_q;
   logic [ADDR_W-1:0] rd_x_q, rd_x_d;
   logic              oce_q;
   logic              we_q;
   logic [ADDR_W:0]   wa_q;
   logic [3:0]        wd_q;
   logic              hs_s1_q, vs_s1_q, vis_s1_q;
   logic [3:0]        rgb_q;
   logic              hsync_q, vsync_q;
   logic              lse;

   assign lse       = vid.pix_ce & hs_prev_q & ~vid.hsync_in;
   assign wr_bank_d = wr_bank_q ^ lse;
   assign wr_addr   = lse ? '0 : wr_x_q;

   always_comb begin
      wr_x_d = wr_x_q;
      if (lse)
         wr_x_d = X_ONE;
      else if (vid.pix_ce && (wr_x_q != X_MAX))
         wr_x_d = wr_x_q + X_ONE;
   end

   always_comb begin
      rd_x_d = rd_x_q;
      if (lse || (line_len_q == '0))
         rd_x_d = '0;
      else if (oce_q)
         rd_x_d = (rd_x_q >= line_len_q - X_ONE) ? '0 : rd_x_q + X_ONE;
   end

   // Writes commit one clk late so the pixel taken at a line start never lands
   // in the bank that is still being read for the tail of the truncated line.
   always_ff @(posedge clk) begin
      if (we_q)
         mem[wa_q] <= wd_q;
      rd_data_q <= mem[{~wr_bank_q, rd_x_q}];
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         hs_prev_q  <= 1'b0;
         vs_hold_q  <= 1'b1;
         wr_x_q     <= '0;
         wr_bank_q  <= 1'b0;
         line_len_q <= '0;
         rd_x_q     <= '0;
         oce_q      <= 1'b0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= 4'h0;
         hs_s1_q    <= 1'b1;
         vs_s1_q    <= 1'b1;
         vis_s1_q   <= 1'b0;
         rgb_q      <= 4'h0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
      end else begin
         if (vid.pix_ce)
            hs_prev_q <= vid.hsync_in;
         if (lse) begin
            line_len_q <= wr_x_q;
            vs_hold_q  <= vid.vsync_in;
         end
         wr_x_q    <= wr_x_d;
         wr_bank_q <= wr_bank_d;
         // Cleared at a line start so pixel 0 of the output line lasts two clks.
         oce_q     <= lse ? 1'b0 : ~oce_q;
         rd_x_q    <= rd_x_d;
         we_q      <= vid.pix_ce;
         wa_q      <= {wr_bank_d, wr_addr};
         wd_q      <= vid.rgb_in;
         hs_s1_q   <= !((line_len_q != '0) && (rd_x_q < HS_W));
         vis_s1_q  <= (rd_x_q >= HS_W) && (rd_x_q < line_len_q);
         vs_s1_q   <= vs_hold_q;
         rgb_q     <= vis_s1_q ? rd_data_q : 4'h0;
         hsync_q   <= hs_s1_q;
         vsync_q   <= vs_s1_q;
      end
   end

   assign vid.rgb_out   = rgb_q;
   assign vid.hsync_out = hsync_q;
   assign vid.vsync_out = vsync_q;
endmodule

// File: tb/tb_scan_doubler.sv
// Directed bench for scan_doubler: outputs are logged every clk and each
// scenario compares the logged window against hand-derived expectations.
module tb_scan_doubler;
   localparam int HSW  = 28;
   localparam int HMAX = 32768;
   localparam int NOVS = 100000;

   logic clk = 1'b0;
   logic nRESET = 1'b1;
   scan_doubler_if vid();

   scan_doubler #(.HS_WIDTH(HSW), .ADDR_W(9)) dut (
      .clk    (clk),
      .nRESET (nRESET),
      .vid    (vid)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   int         e_ln [16];
   logic [3:0] h_rgb [HMAX];
   logic       h_hs  [HMAX];
   logic       h_vs  [HMAX];

   // Expected output at offset t after an output line start, for a stored line.
   function automatic logic [3:0] exp_rgb(input int t, input int len, input int seed);
      int x;
      x = (t / 2) % len;
      return (x >= HSW && x < len) ? 4'((x + seed) % 16) : 4'h0;
   endfunction

   function automatic logic exp_hs(input int t, input int len);
      int x;
      x = (t / 2) % len;
      return (x < HSW) ? 1'b0 : 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (cyc < HMAX) begin
         h_rgb[cyc] = vid.rgb_out;
         h_hs[cyc]  = vid.hsync_out;
         h_vs[cyc]  = vid.vsync_out;
      end
      cyc++;
   endtask

   task automatic pixel(input int n, input int seed, input logic vs);
      vid.pix_ce   = 1'b1;
      vid.rgb_in   = 4'((n + seed) % 16);
      vid.hsync_in = (n < 32) ? 1'b0 : 1'b1;
      vid.vsync_in = vs;
      tick();
      vid.pix_ce = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_line(input int len, input int seed, input int vs_lo_from, output int e);
      e = cyc;
      for (int n = 0; n < len; n++)
         pixel(n, seed, (n >= vs_lo_from) ? 1'b0 : 1'b1);
      $display("line: len=%0d seed=%0d lse_cycle=%0d", len, seed, e);
   endtask

   task automatic test_reset();
      int s;
      vid.pix_ce = 1'b0; vid.rgb_in = 4'h0; vid.hsync_in = 1'b1; vid.vsync_in = 1'b1;
      #1 nRESET = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (vid.rgb_out !== 4'h0) begin n_bad++; $display("FAIL reset_rgb: got %h want 0", vid.rgb_out); end
      n_cmp++;
      if (vid.hsync_out !== 1'b1) begin n_bad++; $display("FAIL reset_hsync: got %b want 1", vid.hsync_out); end
      n_cmp++;
      if (vid.vsync_out !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b want 1", vid.vsync_out); end
      nRESET = 1'b1;
      s = cyc;
      for (int k = 0; k < 8; k++) pixel(100 + k, 0, 1'b1);
      $display("preline: 8 pixels hsync high, no line start");
      for (int i = s; i < cyc; i++) begin
         n_cmp++;
         if (h_rgb[i] !== 4'h0 || h_hs[i] !== 1'b1 || h_vs[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_before_lse cyc=%0d: rgb=%h hs=%b vs=%b want 0/1/1", i, h_rgb[i], h_hs[i], h_vs[i]);
            break;
         end
      end
   endtask

   task automatic test_doubling();
      int low_cnt, p1, p2;
      send_line(384, 0,  NOVS, e_ln[0]);
      send_line(384, 5,  NOVS, e_ln[1]);
      send_line(384, 10, NOVS, e_ln[2]);
      for (int t = 0; t < e_ln[2] - e_ln[1]; t++) begin
         int i;
         i = e_ln[1] + 2 + t;
         n_cmp++;
         if (h_rgb[i] !== exp_rgb(t, 384, 0) || h_hs[i] !== exp_hs(t, 384)) begin
            n_bad++;
            $display("FAIL double_L0 t=%0d: rgb=%h hs=%b want rgb=%h hs=%b",
                     t, h_rgb[i], h_hs[i], exp_rgb(t, 384, 0), exp_hs(t, 384));
            break;
         end
      end
      low_cnt = 0;
      for (int i = e_ln[1] + 2 + 768; i < e_ln[1] + 2 + 1536; i++)
         if (h_hs[i] === 1'b0) low_cnt++;
      n_cmp++;
      if (low_cnt !== 56) begin n_bad++; $display("FAIL hsync_low_width: got %0d want 56", low_cnt); end
      p1 = -1; p2 = -1;
      for (int i = e_ln[1] + 3; i <= e_ln[2] + 2; i++)
         if (h_hs[i-1] === 1'b1 && h_hs[i] === 1'b0) begin
            if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
         end
      n_cmp++;
      if (p1 !== e_ln[1] + 2 + 768) begin n_bad++; $display("FAIL hsync_fall_pos: got %0d want %0d", p1, e_ln[1] + 770); end
      n_cmp++;
      if (p2 - p1 !== 768) begin n_bad++; $display("FAIL hsync_period: got %0d want 768", p2 - p1); end
   endtask

   task automatic test_vsync();
      send_line(384, 3, 100, e_ln[3]);
      send_line(384, 7, 0,   e_ln[4]);
      for (int i = e_ln[2] + 2; i <= e_ln[4] + 1; i++) begin
         n_cmp++;
         if (h_vs[i] !== 1'b1) begin
            n_bad++; $display("FAIL vsync_early cyc=%0d: got %b want 1", i, h_vs[i]);
            break;
         end
      end
      for (int i = e_ln[4] + 2; i < e_ln[4] + 1536; i++) begin
         n_cmp++;
         if (h_vs[i] !== 1'b0) begin
            n_bad++; $display("FAIL vsync_fall cyc=%0d: got %b want 0", i, h_vs[i]);
            break;
         end
      end
      for (int t = 0; t < e_ln[4] - e_ln[3]; t++) begin
         int i;
         i = e_ln[3] + 2 + t;
         n_cmp++;
         if (h_rgb[i] !== exp_rgb(t, 384, 10)) begin
            n_bad++;
            $display("FAIL double_L2 t=%0d: rgb=%h want %h", t, h_rgb[i], exp_rgb(t, 384, 10));
            break;
         end
      end
   endtask

   task automatic test_saturate();
      send_line(600, 9, NOVS, e_ln[5]);
      send_line(384, 2, NOVS, e_ln[6]);
      send_line(320, 4, NOVS, e_ln[7]);
      for (int t = 0; t < e_ln[7] - e_ln[6]; t++) begin
         int i;
         i = e_ln[6] + 2 + t;
         n_cmp++;
         if (h_rgb[i] !== exp_rgb(t, 511, 9) || h_hs[i] !== exp_hs(t, 511)) begin
            n_bad++;
            $display("FAIL saturate_511 t=%0d: rgb=%h hs=%b want rgb=%h hs=%b",
                     t, h_rgb[i], h_hs[i], exp_rgb(t, 511, 9), exp_hs(t, 511));
            break;
         end
      end
   endtask

   task automatic test_len_change();
      send_line(320, 11, NOVS, e_ln[8]);
      send_line(320, 6,  NOVS, e_ln[9]);
      for (int t = 0; t < e_ln[8] - e_ln[7]; t++) begin
         int i;
         i = e_ln[7] + 2 + t;
         n_cmp++;
         if (h_rgb[i] !== exp_rgb(t, 384, 2) || h_hs[i] !== exp_hs(t, 384)) begin
            n_bad++;
            $display("FAIL truncated_384 t=%0d: rgb=%h hs=%b want rgb=%h hs=%b",
                     t, h_rgb[i], h_hs[i], exp_rgb(t, 384, 2), exp_hs(t, 384));
            break;
         end
      end
      for (int t = 0; t < e_ln[9] - e_ln[8]; t++) begin
         int i;
         i = e_ln[8] + 2 + t;
         n_cmp++;
         if (h_rgb[i] !== exp_rgb(t, 320, 4) || h_hs[i] !== exp_hs(t, 320)) begin
            n_bad++;
            $display("FAIL len_320 t=%0d: rgb=%h hs=%b want rgb=%h hs=%b",
                     t, h_rgb[i], h_hs[i], exp_rgb(t, 320, 4), exp_hs(t, 320));
            break;
         end
      end
   endtask

   task automatic test_reset_midline();
      int r0;
      e_ln[10] = cyc;
      for (int n = 0; n < 100; n++) pixel(n, 13, 1'b1);
      nRESET = 1'b0;
      #2;
      $display("reset asserted mid-line at cycle %0d", cyc);
      n_cmp++;
      if (vid.rgb_out !== 4'h0) begin n_bad++; $display("FAIL async_rst_rgb: got %h want 0", vid.rgb_out); end
      n_cmp++;
      if (vid.hsync_out !== 1'b1) begin n_bad++; $display("FAIL async_rst_hsync: got %b want 1", vid.hsync_out); end
      n_cmp++;
      if (vid.vsync_out !== 1'b1) begin n_bad++; $display("FAIL async_rst_vsync: got %b want 1", vid.vsync_out); end
      r0 = cyc;
      repeat (3) tick();
      nRESET = 1'b1;
      for (int n = 100; n < 384; n++) pixel(n, 13, 1'b1);
      send_line(384, 1, NOVS, e_ln[11]);
      send_line(384, 8, NOVS, e_ln[12]);
      e_ln[13] = cyc;
      for (int n = 0; n < 8; n++) pixel(n, 15, 1'b1);
      for (int i = r0; i <= e_ln[11] + 1; i++) begin
         n_cmp++;
         if (h_rgb[i] !== 4'h0 || h_hs[i] !== 1'b1 || h_vs[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_rst cyc=%0d: rgb=%h hs=%b vs=%b want 0/1/1", i, h_rgb[i], h_hs[i], h_vs[i]);
            break;
         end
      end
      for (int t = 0; t < e_ln[13] - e_ln[12]; t++) begin
         int i;
         i = e_ln[12] + 2 + t;
         n_cmp++;
         if (h_rgb[i] !== exp_rgb(t, 384, 1) || h_hs[i] !== exp_hs(t, 384)) begin
            n_bad++;
            $display("FAIL resume_after_rst t=%0d: rgb=%h hs=%b want rgb=%h hs=%b",
                     t, h_rgb[i], h_hs[i], exp_rgb(t, 384, 1), exp_hs(t, 384));
            break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_doubling();
      test_vsync();
      test_saturate();
      test_len_change();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
